// File: rtl/one_3_dispatcher_if.sv
// Flit-level bus between one upstream source and the three dispatcher output ports.
// The master side drives flits and downstream readies; the slave side is the dispatcher.
interface one_3_dispatcher_if #(
  parameter int DW = 16
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_head;
  logic          in_tail;
  logic [1:0]    in_sel;
  logic          in_ready;

  logic [DW-1:0] out1_data;
  logic          out1_valid;
  logic          out1_tail;
  logic          out1_ready;

  logic [DW-1:0] out2_data;
  logic          out2_valid;
  logic          out2_tail;
  logic          out2_ready;

  logic [DW-1:0] out3_data;
  logic          out3_valid;
  logic          out3_tail;
  logic          out3_ready;

  logic          err_drop;

  modport master (
    output in_data, in_valid, in_head, in_tail, in_sel,
    input  in_ready,
    input  out1_data, out1_valid, out1_tail,
    output out1_ready,
    input  out2_data, out2_valid, out2_tail,
    output out2_ready,
    input  out3_data, out3_valid, out3_tail,
    output out3_ready,
    input  err_drop
  );

  modport slave (
    input  in_data, in_valid, in_head, in_tail, in_sel,
    output in_ready,
    output out1_data, out1_valid, out1_tail,
    input  out1_ready,
    output out2_data, out2_valid, out2_tail,
    input  out2_ready,
    output out3_data, out3_valid, out3_tail,
    input  out3_ready,
    output err_drop
  );
endinterface

// File: rtl/one_3_dispatcher.sv
// 1-to-3 packet dispatcher: the head flit's in_sel picks an output port for the whole
// packet; every port has a one-entry output register; bad packets and stray flits are dropped.
module one_3_dispatcher #(
  parameter int DW = 16
) (
  input logic              clk,
  input logic              rst,
  one_3_dispatcher_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] route_q, route_d;
  logic       err_drop_q, err_drop_d;

  logic [2:0] out_ready;
  logic [3:0] free_ext;
  logic [2:0] load_vec;
  logic       ready_c;
  logic       in_xfer;

  logic [DW-1:0] port_data  [3];
  logic          port_tail  [3];
  logic          port_valid [3];

  assign out_ready   = {bus.out3_ready, bus.out2_ready, bus.out1_ready};
  // Index 3 is the invalid destination; it is never free so it can be indexed safely.
  assign free_ext[3] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_port
      logic [DW-1:0] data_q, data_d;
      logic          tail_q, tail_d;
      logic          valid_q, valid_d;

      // A register is free if empty or being drained this cycle.
      assign free_ext[gi] = !valid_q | out_ready[gi];

      always_comb begin
        data_d  = data_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        if (load_vec[gi]) begin
          data_d  = bus.in_data;
          tail_d  = bus.in_tail;
          valid_d = 1'b1;
        end else if (out_ready[gi]) begin
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          data_q  <= '0;
          tail_q  <= 1'b0;
          valid_q <= 1'b0;
        end else begin
          data_q  <= data_d;
          tail_q  <= tail_d;
          valid_q <= valid_d;
        end
      end

      assign port_data[gi]  = data_q;
      assign port_tail[gi]  = tail_q;
      assign port_valid[gi] = valid_q;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    route_d    = route_q;
    err_drop_d = 1'b0;
    load_vec   = 3'b000;
    ready_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_head && bus.in_sel != 2'b11) ready_c = free_ext[bus.in_sel];
        else                                    ready_c = 1'b1;
      end
      FWD:     ready_c = free_ext[route_q];
      DROP:    ready_c = 1'b1;
      default: ready_c = 1'b0;
    endcase

    if (rst) ready_c = 1'b0;
    in_xfer = bus.in_valid & ready_c;

    if (in_xfer) begin
      unique case (state_q)
        IDLE: begin
          if (!bus.in_head) begin
            err_drop_d = 1'b1;
          end else if (bus.in_sel == 2'b11) begin
            err_drop_d = 1'b1;
            state_d    = bus.in_tail ? IDLE : DROP;
          end else begin
            load_vec = 3'b001 << bus.in_sel;
            route_d  = bus.in_sel;
            state_d  = bus.in_tail ? IDLE : FWD;
          end
        end
        // Mid-packet heads are treated as body flits; only the tail ends the packet.
        FWD: begin
          load_vec = 3'b001 << route_q;
          if (bus.in_tail) state_d = IDLE;
        end
        DROP: begin
          if (bus.in_tail) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      route_q    <= 2'b00;
      err_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      route_q    <= route_d;
      err_drop_q <= err_drop_d;
    end
  end

  assign bus.in_ready   = ready_c;
  assign bus.err_drop   = err_drop_q;

  assign bus.out1_data  = port_data[0];
  assign bus.out1_tail  = port_tail[0];
  assign bus.out1_valid = port_valid[0];
  assign bus.out2_data  = port_data[1];
  assign bus.out2_tail  = port_tail[1];
  assign bus.out2_valid = port_valid[1];
  assign bus.out3_data  = port_data[2];
  assign bus.out3_tail  = port_tail[2];
  assign bus.out3_valid = port_valid[2];

endmodule

// File: tb/tb_one_3_dispatcher.sv
// Directed bench for one_3_dispatcher: hand-computed expectations for routing,
// backpressure, drop handling and mid-packet reset.
module tb_one_3_dispatcher;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  one_3_dispatcher_if #(.DW(16)) bus ();

  one_3_dispatcher #(.DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic drive(input logic v, input logic h, input logic t,
                       input logic [1:0] s, input logic [15:0] d);
    bus.in_valid = v;
    bus.in_head  = h;
    bus.in_tail  = t;
    bus.in_sel   = s;
    bus.in_data  = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_valid();
    return bus.out1_valid | bus.out2_valid | bus.out3_valid;
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    bus.out1_ready = 1'b1;
    bus.out2_ready = 1'b1;
    bus.out3_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);

    // Reset state
    step();
    step();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_valid", any_valid(), 0);
    check("rst_out1_data", bus.out1_data, 0);
    check("rst_err_drop", bus.err_drop, 0);
    rst = 1'b0;
    step();

    // 3-flit packet to port2 at full rate
    drive(1'b1, 1'b1, 1'b0, 2'b01, 16'h1111);
    check("p2_ready_head", bus.in_ready, 1);
    step();
    check("p2_f1_valid", bus.out2_valid, 1);
    check("p2_f1_data", bus.out2_data, 32'h1111);
    check("p2_f1_tail", bus.out2_tail, 0);
    check("p2_others_idle", bus.out1_valid | bus.out3_valid, 0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 16'h2222);
    check("p2_ready_body", bus.in_ready, 1);
    step();
    check("p2_f2_data", bus.out2_data, 32'h2222);
    check("p2_f2_tail", bus.out2_tail, 0);
    drive(1'b1, 1'b0, 1'b1, 2'b00, 16'h3333);
    step();
    check("p2_f3_data", bus.out2_data, 32'h3333);
    check("p2_f3_tail", bus.out2_tail, 1);
    check("p2_f3_valid", bus.out2_valid, 1);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    step();
    check("p2_drained", bus.out2_valid, 0);

    // Single-flit to port3 then immediately a packet to port1
    drive(1'b1, 1'b1, 1'b1, 2'b10, 16'hABCD);
    check("sf_ready1", bus.in_ready, 1);
    step();
    check("sf_out3_data", bus.out3_data, 32'hABCD);
    check("sf_out3_tail", bus.out3_tail, 1);
    check("sf_out3_valid", bus.out3_valid, 1);
    drive(1'b1, 1'b1, 1'b1, 2'b00, 16'h5555);
    check("sf_ready2", bus.in_ready, 1);
    step();
    check("sf_out1_data", bus.out1_data, 32'h5555);
    check("sf_out1_valid", bus.out1_valid, 1);
    check("sf_out3_drained", bus.out3_valid, 0);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    step();

    // Backpressure on port1
    bus.out1_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 2'b00, 16'h1001);
    check("bp_ready_head", bus.in_ready, 1);
    step();
    check("bp_head_held", bus.out1_data, 32'h1001);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 16'h1002);
    for (int i = 0; i < 4; i++) begin
      check("bp_stall_ready", bus.in_ready, 0);
      check("bp_stall_data", bus.out1_data, 32'h1001);
      check("bp_stall_valid", bus.out1_valid, 1);
      step();
    end
    bus.out1_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 1);
    step();
    check("bp_body_data", bus.out1_data, 32'h1002);
    check("bp_body_tail", bus.out1_tail, 0);
    drive(1'b1, 1'b0, 1'b1, 2'b00, 16'h1003);
    step();
    check("bp_tail_data", bus.out1_data, 32'h1003);
    check("bp_tail_tail", bus.out1_tail, 1);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    step();
    check("bp_drained", bus.out1_valid, 0);

    // Invalid destination: whole packet dropped, one err_drop pulse
    drive(1'b1, 1'b1, 1'b0, 2'b11, 16'hDEAD);
    check("inv_ready_head", bus.in_ready, 1);
    step();
    check("inv_err_pulse", bus.err_drop, 1);
    check("inv_no_valid1", any_valid(), 0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 16'hD001);
    check("inv_ready_b1", bus.in_ready, 1);
    step();
    check("inv_err_off1", bus.err_drop, 0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 16'hD002);
    check("inv_ready_b2", bus.in_ready, 1);
    step();
    check("inv_err_off2", bus.err_drop, 0);
    check("inv_no_valid2", any_valid(), 0);
    drive(1'b1, 1'b0, 1'b1, 2'b00, 16'hD003);
    check("inv_ready_tail", bus.in_ready, 1);
    step();
    check("inv_err_off3", bus.err_drop, 0);
    check("inv_no_valid3", any_valid(), 0);
    drive(1'b1, 1'b1, 1'b1, 2'b00, 16'h7070);
    step();
    check("inv_next_out1", bus.out1_data, 32'h7070);
    check("inv_next_valid", bus.out1_valid, 1);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    step();

    // Stray body flit in IDLE
    drive(1'b1, 1'b0, 1'b0, 2'b00, 16'hBEEF);
    check("stray_ready", bus.in_ready, 1);
    step();
    check("stray_err", bus.err_drop, 1);
    check("stray_no_valid", any_valid(), 0);
    drive(1'b1, 1'b1, 1'b1, 2'b01, 16'h2468);
    step();
    check("stray_err_off", bus.err_drop, 0);
    check("stray_then_out2", bus.out2_data, 32'h2468);
    check("stray_then_valid", bus.out2_valid, 1);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    step();

    // Reset in the middle of a packet with port2 occupied
    bus.out2_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 2'b01, 16'h3030);
    step();
    check("mr_held", bus.out2_valid, 1);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 16'h3031);
    check("mr_stalled", bus.in_ready, 0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    check("mr_ready_in_rst", bus.in_ready, 0);
    step();
    check("mr_valid_cleared", any_valid(), 0);
    check("mr_out2_data", bus.out2_data, 0);
    check("mr_ready_after", bus.in_ready, 0);
    rst = 1'b0;
    bus.out2_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 2'b00, 16'h7777);
    check("mr_ready_release", bus.in_ready, 1);
    step();
    check("mr_out1_data", bus.out1_data, 32'h7777);
    check("mr_out1_valid", bus.out1_valid, 1);
    check("mr_out2_idle", bus.out2_valid, 0);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
